// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game sequencer between the PS/2 keyboard decoder and snake_field.
// Optional SNAKE_SPEEDUP_EN: step period shrinks as the snake grows.
module snake_game_ctrl #(
    parameter int BASE_PERIOD = 12000000,
    parameter int MIN_PERIOD  = 3000000,
    parameter int SPEED_STEP  = 200000,
    parameter int INIT_LEN    = 3,
    parameter int LEN_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       key,
    input  logic             key_pressed,
    input  logic             snake_alive,
    input  logic [LEN_W-1:0] snake_len,
    output logic             start,
    output logic             step,
    output logic [1:0]       snake_dir,
    output logic             is_running,
    output logic             paused,
    output logic             game_over,
    output logic [LEN_W-1:0] highscore
);

    localparam int PW = $clog2(BASE_PERIOD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_OVER
    } state_t;

    state_t        state, state_nx;
    logic          brk, kv, space, esc;
    logic          kdir_ok;
    logic [1:0]    kdir;
    logic [PW-1:0] cnt, period, per_calc;
    logic [1:0]    q0, q1, q0_nx, q1_nx;
    logic [1:0]    qn, qn_nx, dref;
    logic          go_start, stay_run, tick_end;
    logic          step_fire, hs_chk, hs_upd;
    logic          push_ok, pop;

    assign kv    = key_pressed && !brk &&
                   key != 8'hF0 && key != 8'hE0;
    assign space = kv && key == 8'h29;
    assign esc   = kv && key == 8'h76;

    // Break-code tracking: F0 marks the next byte as a release to drop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            brk <= 1'b0;
        else if (key_pressed)
            brk <= !brk && key == 8'hF0;
    end

    // Map movement keys onto snake directions
    always_comb begin
        kdir    = 2'd0;
        kdir_ok = kv;
        case (key)
            8'h1D:   kdir = 2'd0;
            8'h23:   kdir = 2'd1;
            8'h1B:   kdir = 2'd2;
            8'h1C:   kdir = 2'd3;
            default: kdir_ok = 1'b0;
        endcase
    end

`ifdef SNAKE_SPEEDUP_EN
    localparam int PRW = LEN_W + 32;
    logic [LEN_W-1:0] dlen;
    logic [PRW-1:0]   prod;

    // Shorten the period by SPEED_STEP per segment beyond INIT_LEN
    always_comb begin
        dlen = (snake_len > LEN_W'(INIT_LEN)) ?
               snake_len - LEN_W'(INIT_LEN) : '0;
        prod = PRW'(dlen) * PRW'(SPEED_STEP);
        if (prod >= PRW'(BASE_PERIOD - MIN_PERIOD))
            per_calc = PW'(MIN_PERIOD);
        else
            per_calc = PW'(BASE_PERIOD) - prod[PW-1:0];
    end
`else
    assign per_calc = PW'(BASE_PERIOD);
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; ESC overrides everything, death beats pause
    always_comb begin
        state_nx = state;
        if (esc) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_OVER: if (space) state_nx = S_RUN;
                S_RUN: begin
                    if (!snake_alive)
                        state_nx = S_OVER;
                    else if (space)
                        state_nx = S_PAUSE;
                end
                S_PAUSE: if (space) state_nx = S_RUN;
            endcase
        end
    end

    // Control decode: step timing, highscore trigger, turn queue update
    always_comb begin
        go_start  = space && (state == S_IDLE || state == S_OVER);
        stay_run  = state == S_RUN && state_nx == S_RUN;
        tick_end  = cnt == period - PW'(1);
        step_fire = stay_run && tick_end;
        hs_chk    = esc || (state == S_RUN && state_nx == S_OVER);
        dref      = (qn == 2'd0) ? snake_dir :
                    (qn == 2'd1) ? q0 : q1;
        push_ok   = state == S_RUN && kdir_ok && qn != 2'd2 &&
                    kdir != dref && kdir != (dref ^ 2'd2);
        pop       = step_fire && qn != 2'd0;
        q0_nx     = pop ? q1 : q0;
        q1_nx     = q1;
        qn_nx     = qn - {1'b0, pop};
        if (push_ok) begin
            if (qn_nx == 2'd0)
                q0_nx = kdir;
            else
                q1_nx = kdir;
            qn_nx = qn_nx + 2'd1;
        end
    end

    // Registered outputs, tick counter, period latch and turn queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            period     <= PW'(BASE_PERIOD);
            q0         <= 2'd0;
            q1         <= 2'd0;
            qn         <= 2'd0;
            start      <= 1'b0;
            step       <= 1'b0;
            snake_dir  <= 2'd1;
            is_running <= 1'b0;
            paused     <= 1'b0;
            game_over  <= 1'b0;
            highscore  <= '0;
            hs_upd     <= 1'b0;
        end else begin
            start      <= go_start;
            step       <= step_fire;
            is_running <= state_nx == S_RUN;
            paused     <= state_nx == S_PAUSE;
            game_over  <= state_nx == S_OVER;
            hs_upd     <= hs_chk;
            if (hs_upd && snake_len > highscore)
                highscore <= snake_len;
            q0 <= q0_nx;
            q1 <= q1_nx;
            qn <= qn_nx;
            if (esc) begin
                cnt <= '0;
                qn  <= 2'd0;
            end else if (go_start) begin
                cnt       <= '0;
                qn        <= 2'd0;
                period    <= PW'(BASE_PERIOD);
                snake_dir <= 2'd1;
            end else if (step_fire) begin
                cnt    <= '0;
                period <= per_calc;
                if (qn != 2'd0)
                    snake_dir <= q0;
            end else if (stay_run) begin
                cnt <= cnt + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: randomized scoreboard bench for snake_game_ctrl.
// Game-level reference model predicts pulses and status every clock.
module tb_snake_game_ctrl;

    localparam int BP = 10;
    localparam int MP = 4;
    localparam int SS = 2;
    localparam int IL = 3;
    localparam int LW = 8;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVER  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    key = 8'h00;
    logic          kp = 1'b0;
    logic          alive = 1'b1;
    logic [LW-1:0] len = 8'd3;
    logic          start, step, is_running, paused, game_over;
    logic [1:0]    snake_dir;
    logic [LW-1:0] highscore;

    snake_game_ctrl #(
        .BASE_PERIOD(BP),
        .MIN_PERIOD (MP),
        .SPEED_STEP (SS),
        .INIT_LEN   (IL),
        .LEN_W      (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_pressed(kp),
        .snake_alive(alive),
        .snake_len  (len),
        .start      (start),
        .step       (step),
        .snake_dir  (snake_dir),
        .is_running (is_running),
        .paused     (paused),
        .game_over  (game_over),
        .highscore  (highscore)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e;
        bit is_step;
        int dir;
    } ev_t;

    typedef struct {
        int e;
        bit run;
        bit pau;
        bit ovr;
        int dir;
        int hs;
    } sn_t;

    ev_t evq[$];
    sn_t snq[$];

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    int m_st;
    bit m_brk;
    int m_q[$];
    int m_dir;
    int m_ticks;
    int m_per;
    int m_hs;
    bit m_pend;

    bit       g_alive = 1'b1;
    bit [7:0] g_len = 8'd3;

    always @(posedge clk) edge_n++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)",
                     nm, act, exp, edge_n);
        end
    endtask

    function automatic int period_of(input int l);
`ifdef SNAKE_SPEEDUP_EN
        int d;
        d = (l > IL) ? l - IL : 0;
        if (d * SS >= BP - MP)
            return MP;
        return BP - d * SS;
`else
        return BP + 0 * l;
`endif
    endfunction

    task automatic model_reset();
        m_st    = M_IDLE;
        m_brk   = 1'b0;
        m_q.delete();
        m_dir   = 1;
        m_ticks = 0;
        m_per   = BP;
        m_hs    = 0;
        m_pend  = 1'b0;
    endtask

    // Predict what edge e does with the inputs currently applied
    task automatic predict(input int e);
        bit  v, isd, acc, pend_old, sp, es;
        int  d, refd;
        ev_t ev;
        sn_t s;
        v = kp && !m_brk && key != 8'hF0 && key != 8'hE0;
        if (kp)
            m_brk = !m_brk && key == 8'hF0;
        sp  = v && key == 8'h29;
        es  = v && key == 8'h76;
        isd = 1'b0;
        d   = 0;
        if (v) begin
            case (key)
                8'h1D: begin isd = 1'b1; d = 0; end
                8'h23: begin isd = 1'b1; d = 1; end
                8'h1B: begin isd = 1'b1; d = 2; end
                8'h1C: begin isd = 1'b1; d = 3; end
                default: isd = 1'b0;
            endcase
        end
        pend_old = m_pend;
        m_pend   = 1'b0;
        if (pend_old && int'(len) > m_hs)
            m_hs = int'(len);
        if (es) begin
            m_st    = M_IDLE;
            m_q.delete();
            m_ticks = 0;
            m_pend  = 1'b1;
        end else begin
            case (m_st)
                M_IDLE, M_OVER: begin
                    if (sp) begin
                        m_st    = M_RUN;
                        m_dir   = 1;
                        m_q.delete();
                        m_ticks = 0;
                        m_per   = BP;
                        ev.e = e; ev.is_step = 1'b0; ev.dir = 1;
                        evq.push_back(ev);
                    end
                end
                M_RUN: begin
                    refd = (m_q.size() > 0) ? m_q[$] : m_dir;
                    acc  = isd && m_q.size() < 2 &&
                           d != refd && d != (refd ^ 2);
                    if (!alive) begin
                        m_st   = M_OVER;
                        m_pend = 1'b1;
                    end else if (sp) begin
                        m_st = M_PAUSE;
                    end else begin
                        m_ticks++;
                        if (m_ticks == m_per) begin
                            m_ticks = 0;
                            if (m_q.size() > 0)
                                m_dir = m_q.pop_front();
                            m_per = period_of(int'(len));
                            ev.e = e; ev.is_step = 1'b1; ev.dir = m_dir;
                            evq.push_back(ev);
                        end
                    end
                    if (acc)
                        m_q.push_back(d);
                end
                default: begin
                    if (sp)
                        m_st = M_RUN;
                end
            endcase
        end
        s.e   = e;
        s.run = m_st == M_RUN;
        s.pau = m_st == M_PAUSE;
        s.ovr = m_st == M_OVER;
        s.dir = m_dir;
        s.hs  = m_hs;
        snq.push_back(s);
    endtask

    task automatic drive(input logic [7:0] k, input bit p);
        key   = k;
        kp    = p;
        alive = g_alive;
        len   = g_len;
        predict(edge_n + 1);
    endtask

    task automatic cyc(input logic [7:0] k, input bit p);
        @(posedge clk);
        #1;
        drive(k, p);
    endtask

    task automatic press(input logic [7:0] k);
        cyc(k, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(8'($urandom), 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_step"}, step, 0);
        chk({tag, "_dir"}, snake_dir, 1);
        chk({tag, "_run"}, is_running, 0);
        chk({tag, "_pause"}, paused, 0);
        chk({tag, "_over"}, game_over, 0);
        chk({tag, "_hs"}, highscore, 0);
    endtask

    // Monitor: pop expected pulses and per-edge status when the DUT shows them
    always @(negedge clk) begin
        ev_t ev;
        if (rst) begin
            if (start || step) begin
                if (evq.size() == 0 || evq[0].e != edge_n) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse: unexpected start=%0d step=%0d at edge %0d",
                             start, step, edge_n);
                end else begin
                    ev = evq.pop_front();
                    chk("pulse_step", step, ev.is_step);
                    chk("pulse_start", start, !ev.is_step);
                    if (ev.is_step)
                        chk("step_dir", snake_dir, ev.dir);
                end
            end
            while (evq.size() > 0 && evq[0].e <= edge_n) begin
                ev = evq.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_pulse: got none, expected %s at edge %0d",
                         ev.is_step ? "step" : "start", ev.e);
            end
            while (snq.size() > 0 && snq[0].e < edge_n)
                void'(snq.pop_front());
            if (snq.size() > 0 && snq[0].e == edge_n) begin
                chk("is_running", is_running, snq[0].run);
                chk("paused", paused, snq[0].pau);
                chk("game_over", game_over, snq[0].ovr);
                chk("snake_dir", snake_dir, snq[0].dir);
                chk("highscore", highscore, snq[0].hs);
                void'(snq.pop_front());
            end
        end
    end

    int r;

    initial begin
        model_reset();
        #2 rst = 1'b0;
        #1 check_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(8'h00, 1'b0);
        idle(3);

        // start, then three plain steps
        press(8'h29);
        idle(35);
        // two turns within one period, then a reversal
        press(8'h1D);
        idle(2);
        press(8'h1C);
        idle(30);
        press(8'h23);
        idle(25);
        // third queued turn is rejected as full
        press(8'h1D);
        press(8'h1C);
        press(8'h1B);
        idle(40);
        // length-dependent period
        g_len = 8'd5;
        idle(40);
        g_len = 8'd9;
        idle(40);
        g_len = 8'd3;
        idle(12);
        // pause mid-interval and resume
        idle($urandom_range(0, 9));
        press(8'h29);
        idle(50);
        press(8'h29);
        idle(20);
        // release code and extended prefix
        press(8'hF0);
        press(8'h29);
        idle(5);
        press(8'hE0);
        press(8'h1D);
        idle(15);
        // death at length 7, restart, death at length 5
        g_len = 8'd7;
        g_alive = 1'b0;
        idle(3);
        g_alive = 1'b1;
        idle(5);
        press(8'h29);
        idle(30);
        g_len = 8'd5;
        g_alive = 1'b0;
        idle(3);
        g_alive = 1'b1;
        idle(3);
        // escape back to idle
        press(8'h29);
        idle(15);
        press(8'h76);
        idle(5);

        // randomized play
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0)
                g_len = 8'($urandom_range(0, 14));
            r = $urandom_range(0, 99);
            if (r < 60) begin
                idle(1);
            end else if (r < 85) begin
                case ($urandom_range(0, 3))
                    0: press(8'h1D);
                    1: press(8'h23);
                    2: press(8'h1B);
                    default: press(8'h1C);
                endcase
            end else if (r < 89) begin
                press(8'h29);
            end else if (r < 90) begin
                press(8'h76);
            end else if (r < 93) begin
                press(8'hF0);
                press(8'($urandom));
            end else if (r < 95) begin
                press(8'hE0);
            end else if (r < 98) begin
                press(8'($urandom));
            end else begin
                g_alive = 1'b0;
                idle(1);
                g_alive = 1'b1;
            end
        end

        // asynchronous reset in the middle of a game
        g_alive = 1'b1;
        press(8'h76);
        press(8'h29);
        idle(7);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async");
        evq.delete();
        snq.delete();
        model_reset();
        key = 8'h00;
        kp  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(8'h00, 1'b0);
        idle(3);
        press(8'h29);
        idle(25);

        @(posedge clk);
        @(negedge clk);
        while (evq.size() > 0) begin
            ev_t ev;
            ev = evq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse: got none, expected %s at edge %0d",
                     ev.is_step ? "step" : "start", ev.e);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Game sequencer that sits between the PS/2 `keyboard` decoder and `snake_field`.
- Owns the game state machine (idle/run/pause/over) and produces `start` and `step` pulses.
- Buffers direction commands in a 2-entry queue so that at most one turn is applied per step.
- Scales step rate with snake length and tracks the highscore.

Parameters:
- BASE_PERIOD, 12000000, clocks between steps at initial length.
- MIN_PERIOD, 3000000, lower clamp on step period.
- SPEED_STEP, 200000, period reduction per segment above INIT_LEN.
- INIT_LEN, 3, snake length right after start.
- LEN_W, 8, width of snake_len/highscore.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- key  in  8  PS/2 scan code byte.
- key_pressed  in  1  one-cycle strobe, key valid.
- snake_alive  in  1  from `snake_field`.
- snake_len  in  LEN_W  current length.
- start  out  1  one-cycle pulse: re-init field.
- step  out  1  one-cycle pulse: advance snake.
- snake_dir  out  2  0 up, 1 right, 2 down, 3 left.
- is_running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- game_over  out  1  high in OVER.
- highscore  out  LEN_W  best length since reset.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; queue empty; tick counter 0; break flag 0.
  - Outputs: snake_dir=1, highscore=0, all other outputs 0.
- Key filtering:
  - 0xF0 sets break flag; the next byte is discarded and clears the flag.
  - 0xE0 is discarded.
  - Codes used: SPACE 0x29, ESC 0x76, W 0x1D→0, D 0x23→1, S 0x1B→2, A 0x1C→3. All other codes are ignored.
- FSM (is_running / paused / game_over are registered decodes of state):
  - IDLE: SPACE → RUN; assert start for 1 cycle; snake_dir←1; flush queue; counter←0; period←BASE_PERIOD.
  - RUN: SPACE → PAUSE. snake_alive=0 → OVER, with no further step. Both in the same cycle → OVER wins.
  - PAUSE: SPACE → RUN. Counter and queue are held.
  - OVER: SPACE → RUN with the same actions as from IDLE (restart).
  - ESC in any state → IDLE; flush queue; counter←0.
- Tick counter (RUN only):
  - Increments each clock.
  - When counter==period-1: counter←0, and step=1 on the next edge.
  - On the edge where step rises, snake_dir←queue head (if non-empty) and the head is popped. snake_dir and step therefore change together.
  - Period is latched at each step and at start; it never changes mid-interval.
- Period arithmetic:
  - d = snake_len - INIT_LEN, saturating at 0.
  - period = BASE_PERIOD - d*SPEED_STEP.
  - If d*SPEED_STEP ≥ BASE_PERIOD-MIN_PERIOD, period = MIN_PERIOD.
  - All intermediates have enough width that nothing wraps.
- Direction queue (depth 2), pushed only in RUN:
  - Reference direction = last queued entry, or snake_dir if the queue is empty.
  - A push is rejected if the queue is full, if dir == reference, or if dir == reference^2 (reversal).
  - Push and pop in the same cycle are both performed; the reference is the pre-pop tail.
  - A push into an empty queue in the step cycle is applied at the following step.
- Highscore:
  - On RUN→OVER and on ESC, highscore←snake_len if snake_len > highscore.
  - Updated one cycle after the transition.
- start and step are never high in the same cycle.

Optional Feature:
- Macro SNAKE_SPEEDUP_EN.
  - Defined: the period scales with length as above.
  - Undefined: period is always BASE_PERIOD, and the snake_len input is used only for highscore.

Test Plan (BASE_PERIOD=10, MIN_PERIOD=4, SPEED_STEP=2, INIT_LEN=3, SNAKE_SPEEDUP_EN defined unless stated):
- Reset, SPACE → start high for exactly 1 cycle; is_running=1; step pulses every 10 clocks; snake_dir=1.
- In RUN, press W then A within one period → dir 0 at next step, 3 at the step after. Press D while dir=3 with queue empty → rejected (reversal). Three keys W, A, S in one period → third is rejected (full).
- snake_len=5 → period 6; snake_len=9 → period 4 (clamped). Without SNAKE_SPEEDUP_EN, snake_len=9 → period 10.
- SPACE mid-interval at counter=4 → PAUSE with no steps for 50 clocks; SPACE again → next step 6 clocks later.
- snake_alive drops with snake_len=7, highscore=0 → OVER, no further step, highscore=7. Restart with SPACE → start pulse; a later game dying at len 5 keeps highscore=7.
- Sequence F0,29 → no state change. Assert rst low mid-RUN → all outputs reset immediately without waiting for a clock.
